// File: rtl/uart_rx_controller.sv
// UART receiver front end: acks every byte and buffers good bytes in a FWFT FIFO.
// Ack rises one edge after rxSent. Bytes that arrive with the FIFO full are counted as overflow and dropped.
`timescale 1ns/1ps
module uart_rx_controller #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rxData,
  input  logic              rxSent,
  input  logic [3:0]        rxError,
  output logic              rxRecieved,
  input  logic              rdEn,
  output logic [7:0]        rdData,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic [CNT_W-1:0]  parityErrCnt,
  output logic [CNT_W-1:0]  frameErrCnt,
  output logic [CNT_W-1:0]  overflowCnt,
  input  logic              clrCnt
);

  localparam logic [1:0]      ST_IDLE  = 2'd0;
  localparam logic [1:0]      ST_ACK   = 2'd1;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  logic [1:0]        r_state;
  logic              r_ack;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic [3:0]        r_prev_err;
  logic [CNT_W-1:0]  r_par_cnt;
  logic [CNT_W-1:0]  r_frm_cnt;
  logic [CNT_W-1:0]  r_ovf_cnt;

  logic w_full, w_empty, w_capture, w_slot, w_push, w_drop, w_pop;
  logic w_err_evt, w_par_evt, w_frm_evt;

  assign w_full    = (r_level == LVL_FULL);
  assign w_empty   = (r_level == '0);
  assign w_capture = (r_state == ST_IDLE) && rxSent;
  // A full FIFO still accepts when the consumer pops on the same edge.
  assign w_slot    = !w_full || rdEn;
  assign w_push    = w_capture && w_slot;
  assign w_drop    = w_capture && !w_slot;
  assign w_pop     = rdEn && !w_empty;
  assign w_err_evt = (rxError != 4'd0) && (rxError != r_prev_err);
  assign w_par_evt = w_err_evt && (rxError == 4'd1);
  assign w_frm_evt = w_err_evt && (rxError == 4'd2);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (rxSent) begin
          r_state <= ST_ACK;
          r_ack   <= 1'b1;
        end
        ST_ACK: if (!rxSent) begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wr_ptr] <= rxData;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_err <= '0;
      r_par_cnt  <= '0;
      r_frm_cnt  <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      r_prev_err <= rxError;
      if (clrCnt) begin
        r_par_cnt <= '0;
        r_frm_cnt <= '0;
        r_ovf_cnt <= '0;
      end else begin
        if (w_par_evt) r_par_cnt <= sat_inc(r_par_cnt);
        if (w_frm_evt) r_frm_cnt <= sat_inc(r_frm_cnt);
        if (w_drop)    r_ovf_cnt <= sat_inc(r_ovf_cnt);
      end
    end
  end

  assign rxRecieved   = r_ack;
  assign rdData       = r_mem[r_rd_ptr];
  assign empty        = w_empty;
  assign full         = w_full;
  assign level        = r_level;
  assign parityErrCnt = r_par_cnt;
  assign frameErrCnt  = r_frm_cnt;
  assign overflowCnt  = r_ovf_cnt;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: queue-based reference model plus a read-side scoreboard monitor.
`timescale 1ns/1ps
module tb_uart_rx_controller;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, rxSent, rdEn, clrCnt;
  logic [7:0] rxData;
  logic [3:0] rxError;
  logic       rxRecieved, empty, full;
  logic [7:0] rdData;
  logic [2:0] level;
  logic [7:0] parityErrCnt, frameErrCnt, overflowCnt;
  logic       rxRecieved2, empty2, full2;
  logic [7:0] rdData2;
  logic [2:0] level2;
  logic [1:0] par2, frm2, ovf2;

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned m_q[$];
  byte unsigned sb_q[$];
  bit           m_ack;
  int           m_par, m_frm, m_ovf;
  logic [3:0]   m_prev;

  always #5 clk = ~clk;

  uart_rx_controller #(.DEPTH(DEPTH), .ADDR_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rxData(rxData), .rxSent(rxSent), .rxError(rxError),
    .rxRecieved(rxRecieved), .rdEn(rdEn), .rdData(rdData), .empty(empty), .full(full),
    .level(level), .parityErrCnt(parityErrCnt), .frameErrCnt(frameErrCnt),
    .overflowCnt(overflowCnt), .clrCnt(clrCnt));

  uart_rx_controller #(.DEPTH(DEPTH), .ADDR_W(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .rxData(rxData), .rxSent(rxSent), .rxError(rxError),
    .rxRecieved(rxRecieved2), .rdEn(rdEn), .rdData(rdData2), .empty(empty2), .full(full2),
    .level(level2), .parityErrCnt(par2), .frameErrCnt(frm2),
    .overflowCnt(ovf2), .clrCnt(clrCnt));

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int sat(int n, int mx);
    return (n > mx) ? mx : n;
  endfunction

  // Applies the spec rules for the coming edge to the model, then advances one cycle.
  task automatic tick();
    bit cap, acc;
    if (!rst_n) begin
      m_q.delete(); sb_q.delete();
      m_ack = 0; m_par = 0; m_frm = 0; m_ovf = 0; m_prev = 4'd0;
    end else begin
      cap = !m_ack && rxSent;
      acc = cap && (m_q.size() < DEPTH || rdEn);
      if (rdEn && m_q.size() > 0) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(rxData);
        sb_q.push_back(rxData);
      end
      if (cap) m_ack = 1;
      else if (!rxSent) m_ack = 0;
      if (clrCnt) begin
        m_par = 0; m_frm = 0; m_ovf = 0;
      end else begin
        if (cap && !acc) m_ovf++;
        if (rxError != 4'd0 && rxError != m_prev) begin
          if (rxError == 4'd1) m_par++;
          else if (rxError == 4'd2) m_frm++;
        end
      end
      m_prev = rxError;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    check("rxRecieved", rxRecieved, m_ack);
    check("level", level, m_q.size());
    check("empty", empty, m_q.size() == 0);
    check("full", full, m_q.size() == DEPTH);
    if (m_q.size() > 0) check("rdData_head", rdData, m_q[0]);
    check("parityErrCnt", parityErrCnt, sat(m_par, 255));
    check("frameErrCnt", frameErrCnt, sat(m_frm, 255));
    check("overflowCnt", overflowCnt, sat(m_ovf, 255));
    check("parityErrCnt_w2", par2, sat(m_par, 3));
    check("frameErrCnt_w2", frm2, sat(m_frm, 3));
    check("overflowCnt_w2", ovf2, sat(m_ovf, 3));
  endtask

  task automatic deliver(input logic [7:0] b, input logic rd);
    int n;
    rxData = b; rxSent = 1'b1; rdEn = rd;
    tick(); rdEn = 1'b0; check_all();
    n = 0;
    while (!rxRecieved && n < 8) begin
      tick(); check_all(); n++;
    end
    if (!rxRecieved) check("deliver_ack_timeout", rxRecieved, 1);
    rxSent = 1'b0;
    tick(); check_all();
  endtask

  task automatic read1();
    rdEn = 1'b1; tick(); rdEn = 1'b0; check_all();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rdEn && !empty) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL mon_pop actual=data %02h required=no pop (scoreboard empty)", rdData);
      end else begin
        check("mon_pop_data", rdData, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    byte unsigned fp_exp[4];
    int n;
    rst_n = 1'b0; rxSent = 1'b1; rxData = 8'hAA; rxError = 4'd0; rdEn = 1'b0; clrCnt = 1'b0;
    tick(); tick();
    check_all();
    check("rst_ack", rxRecieved, 0);
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    rst_n = 1'b1;
    tick(); check_all();
    check("post_rst_ack", rxRecieved, 1);
    rxSent = 1'b0; tick(); check_all();
    read1();

    // Single good byte
    rxData = 8'h5A; rxSent = 1'b1;
    tick(); check_all();
    check("gb_ack_rise", rxRecieved, 1);
    check("gb_level", level, 1);
    check("gb_data", rdData, 8'h5A);
    rxSent = 1'b0;
    tick(); check_all();
    check("gb_ack_fall", rxRecieved, 0);
    read1();
    check("gb_empty", empty, 1);

    // Fill and overflow
    clrCnt = 1'b1; tick(); clrCnt = 1'b0; check_all();
    for (int i = 1; i <= 4; i++) deliver(8'(i), 1'b0);
    check("fill_full", full, 1);
    check("fill_level", level, 4);
    deliver(8'h05, 1'b0);
    check("fill_ovf", overflowCnt, 1);
    for (int i = 1; i <= 4; i++) begin
      check("fill_order", rdData, i);
      read1();
    end

    // Full with simultaneous pop
    for (int i = 1; i <= 4; i++) deliver(8'(i), 1'b0);
    deliver(8'h10, 1'b1);
    check("fp_level", level, 4);
    check("fp_ovf", overflowCnt, 1);
    fp_exp = '{8'h02, 8'h03, 8'h04, 8'h10};
    for (int i = 0; i < 4; i++) begin
      check("fp_order", rdData, fp_exp[i]);
      read1();
    end

    // Error events
    rxError = 4'd1;
    repeat (10) begin tick(); check_all(); end
    rxError = 4'd0; tick(); check_all();
    rxError = 4'd2; tick(); check_all();
    rxError = 4'd1; tick(); check_all();
    rxError = 4'd0; tick(); check_all();
    check("err_par", parityErrCnt, 2);
    check("err_frm", frameErrCnt, 1);
    check("err_level", level, 0);
    clrCnt = 1'b1; tick(); clrCnt = 1'b0; check_all();
    check("clr_par", parityErrCnt, 0);
    check("clr_frm", frameErrCnt, 0);
    check("clr_ovf", overflowCnt, 0);

    // Saturation on the narrow-counter instance
    repeat (5) begin
      rxError = 4'd2; tick(); check_all();
      rxError = 4'd0; tick(); check_all();
    end
    check("sat_frm_w2", frm2, 3);
    check("sat_frm_w8", frameErrCnt, 5);

    // Underflow
    rdEn = 1'b1; tick(); tick(); rdEn = 1'b0; check_all();
    check("uf_level", level, 0);
    check("uf_empty", empty, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rxData  = 8'($urandom);
      rxSent  = 1'($urandom_range(0, 1));
      rdEn    = ($urandom_range(0, 2) == 0);
      clrCnt  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) rxError = 4'($urandom_range(0, 3));
      tick(); check_all();
    end

    rxSent = 1'b0; rdEn = 1'b0; clrCnt = 1'b0; rxError = 4'd0;
    tick(); check_all();
    n = 0;
    while (!empty && n < 8) begin
      read1(); n++;
    end
    check("drain_empty", empty, 1);
    check("sb_drained", sb_q.size(), m_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
